// File: rtl/ntt_op_test_sca_if.sv
// rtl/ntt_op_test_sca_if.sv - control/data bundle for the 8-point NTT SCA target
interface ntt_op_test_sca_if;
  logic         start;
  logic [2:0]   mode;
  logic         validi;
  logic [131:0] in;
  logic [135:0] out;
  logic         done;
  logic         busy;
  logic         trigger;

  modport master (
    output start, mode, validi, in,
    input  out, done, busy, trigger
  );

  modport slave (
    input  start, mode, validi, in,
    output out, done, busy, trigger
  );
endinterface

// File: rtl/ntt_op_test_sca.sv
// rtl/ntt_op_test_sca.sv - 8-point cyclic NTT/INTT over Z_65537, one butterfly per cycle
module ntt_op_test_sca (
  input  logic             clk,
  input  logic             rst,
  ntt_op_test_sca_if.slave bus
);
  localparam logic [16:0] NINV = 17'd57345;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SCALE, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   step_q, step_d;
  logic [2:0]   mode_q, mode_d;
  logic [16:0]  buf_q [8];
  logic [16:0]  buf_d [8];
  logic [16:0]  work_q [8];
  logic [16:0]  work_d [8];
  logic [135:0] out_q, out_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [2:0]   idx_a, idx_b;
  logic [1:0]   tw_idx;
  logic [16:0]  tw, mul_a, mul_b, prod;
  logic         enter_done;
  logic         unused_in;

  assign unused_in = ^bus.in[131:128];

  // x = hi*2^16 + lo and 2^16 == -1 (mod Q), so x == lo - hi
  function automatic logic [16:0] mod_mul(input logic [16:0] a, input logic [16:0] b);
    logic [33:0]        p;
    logic signed [18:0] r;
    p = {17'd0, a} * {17'd0, b};
    r = $signed({3'b000, p[15:0]}) - $signed({1'b0, p[33:16]});
    if (r < 0) r = r + 19'sd65537;
    return r[16:0];
  endfunction

  function automatic logic [16:0] mod_add(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 18'd65537) s = s - 18'd65537;
    return s[16:0];
  endfunction

  function automatic logic [16:0] mod_sub(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + 18'd65537;
    return d[16:0];
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Butterfly addressing: step[3:2] is the stage, step[1:0] the butterfly within it
  always_comb begin
    idx_a  = 3'd0;
    tw_idx = 2'd0;
    case (step_q[3:2])
      2'd0: begin
        idx_a  = {step_q[1:0], 1'b0};
        tw_idx = 2'd0;
      end
      2'd1: begin
        idx_a  = {step_q[1], 1'b0, step_q[0]};
        tw_idx = {step_q[0], 1'b0};
      end
      default: begin
        idx_a  = {1'b0, step_q[1:0]};
        tw_idx = step_q[1:0];
      end
    endcase
    case (step_q[3:2])
      2'd0:    idx_b = idx_a + 3'd1;
      2'd1:    idx_b = idx_a + 3'd2;
      default: idx_b = idx_a + 3'd4;
    endcase

    tw = 17'd1;
    if (mode_q == 3'd1) begin
      case (tw_idx)
        2'd0: tw = 17'd1;
        2'd1: tw = 17'd61441;
        2'd2: tw = 17'd65281;
        default: tw = 17'd65521;
      endcase
    end else begin
      case (tw_idx)
        2'd0: tw = 17'd1;
        2'd1: tw = 17'd16;
        2'd2: tw = 17'd256;
        default: tw = 17'd4096;
      endcase
    end

    if (state_q == S_SCALE) begin
      mul_a = work_q[step_q[2:0]];
      mul_b = NINV;
    end else begin
      mul_a = tw;
      mul_b = work_q[idx_b];
    end
    prod = mod_mul(mul_a, mul_b);
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mode_d     = mode_q;
    buf_d      = buf_q;
    work_d     = work_q;
    out_d      = out_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    enter_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.validi) begin
          for (int k = 0; k < 8; k++) buf_d[k] = {1'b0, bus.in[16*k +: 16]};
        end
        if (bus.start) begin
          mode_d  = bus.mode;
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        step_d = 4'd0;
        if (mode_q <= 3'd1) begin
          for (int i = 0; i < 8; i++) work_d[i] = buf_q[bitrev3(3'(i))];
          state_d = S_RUN;
        end else begin
          for (int i = 0; i < 8; i++) work_d[i] = buf_q[i];
          enter_done = 1'b1;
        end
      end
      S_RUN: begin
        work_d[idx_a] = mod_add(work_q[idx_a], prod);
        work_d[idx_b] = mod_sub(work_q[idx_a], prod);
        step_d        = step_q + 4'd1;
        if (step_q == 4'd11) begin
          step_d = 4'd0;
          if (mode_q == 3'd1) state_d = S_SCALE;
          else                enter_done = 1'b1;
        end
      end
      S_SCALE: begin
        work_d[step_q[2:0]] = prod;
        step_d              = step_q + 4'd1;
        if (step_q == 4'd7) begin
          step_d     = 4'd0;
          enter_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Publish the just-computed result in the same edge that raises done
    if (enter_done) begin
      for (int k = 0; k < 8; k++) out_d[17*k +: 17] = work_d[k];
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      mode_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        buf_q[i]  <= '0;
        work_q[i] <= '0;
      end
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
      work_q  <= work_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.trigger = busy_q;
endmodule

// File: tb/tb_ntt_op_test_sca.sv
// tb/tb_ntt_op_test_sca.sv - directed and random checks of the NTT engine against a DFT model
module tb_ntt_op_test_sca;
  localparam longint Q = 65537;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  ntt_op_test_sca_if bus_if ();

  ntt_op_test_sca dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic longint pw(input longint b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // Direct O(N^2) DFT over Z_Q
  function automatic logic [135:0] model(input logic [131:0] vin, input logic [2:0] m);
    logic [135:0] r = '0;
    longint x [8];
    longint acc;
    for (int n = 0; n < 8; n++) x[n] = longint'(vin[16*n +: 16]);
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      if (m == 3'd0) begin
        for (int n = 0; n < 8; n++) acc = (acc + x[n] * pw(16, n * k)) % Q;
      end else if (m == 3'd1) begin
        for (int n = 0; n < 8; n++) acc = (acc + x[n] * pw(61441, n * k)) % Q;
        acc = (acc * 57345) % Q;
      end else begin
        acc = x[k];
      end
      r[17*k +: 17] = 17'(acc);
    end
    return r;
  endfunction

  function automatic logic [135:0] pack8(input int v [8]);
    logic [135:0] r = '0;
    for (int k = 0; k < 8; k++) r[17*k +: 17] = 17'(v[k]);
    return r;
  endfunction

  task automatic check_vec(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [131:0] vin, input logic [2:0] m,
                        input bit load, input logic [135:0] exp);
    int lat;
    int exp_lat;
    logic [135:0] res;
    exp_lat = (m == 3'd0) ? 13 : (m == 3'd1) ? 21 : 1;
    @(negedge clk);
    bus_if.in     = vin;
    bus_if.validi = load;
    bus_if.mode   = m;
    bus_if.start  = 1'b1;
    @(posedge clk); #1;
    bus_if.start  = 1'b0;
    bus_if.validi = 1'b0;
    bus_if.mode   = m ^ 3'b101;
    bus_if.in     = ~vin;
    check_int({tag, "_busy"}, int'(bus_if.busy), 1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check_int({tag, "_latency"}, lat, exp_lat);
    res = bus_if.out;
    check_vec({tag, "_out"}, res, exp);
    check_int({tag, "_trigger_at_done"}, int'({bus_if.busy, bus_if.trigger}), 0);
    @(posedge clk); #1;
    check_int({tag, "_done_pulse"}, int'(bus_if.done), 0);
    check_vec({tag, "_hold"}, bus_if.out, exp);
  endtask

  initial begin
    logic [131:0] vin;
    logic [131:0] x_keep;
    int e [8];
    int ndone;
    logic [2:0] m;

    bus_if.start  = 1'b0;
    bus_if.validi = 1'b0;
    bus_if.mode   = 3'd0;
    bus_if.in     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_vec("reset_out", bus_if.out, '0);
    check_int("reset_flags", int'({bus_if.done, bus_if.busy, bus_if.trigger}), 0);

    e = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_op("fwd_delta", 132'h1, 3'd0, 1'b1, pack8(e));

    vin = '0;
    for (int k = 0; k < 8; k++) vin[16*k +: 16] = 16'd3;
    e = '{24, 0, 0, 0, 0, 0, 0, 0};
    run_op("fwd_const", vin, 3'd0, 1'b1, pack8(e));

    e = '{1, 16, 256, 4096, 65536, 65521, 65281, 61441};
    run_op("fwd_twiddle", 132'h1 << 16, 3'd0, 1'b1, pack8(e));

    vin = '0;
    for (int k = 0; k < 8; k++) vin[16*k +: 16] = 16'd1;
    e = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_op("inv_const", vin, 3'd1, 1'b1, pack8(e));

    e = '{57345, 57345, 57345, 57345, 57345, 57345, 57345, 57345};
    run_op("inv_delta", 132'h1, 3'd1, 1'b1, pack8(e));

    e = '{'hca8e, 'h4803, 'h46df, 'h0ad0, 0, 0, 0, 0};
    run_op("pass", 132'h0ad046df4803ca8e, 3'd3, 1'b1, pack8(e));

    vin = '0;
    for (int k = 0; k < 8; k++) vin[16*k +: 16] = 16'hffff;
    run_op("fwd_max", vin, 3'd0, 1'b1, model(vin, 3'd0));
    run_op("inv_max", vin, 3'd1, 1'b1, model(vin, 3'd1));

    for (int t = 0; t < 6; t++) begin
      vin = {4'($urandom), $urandom, $urandom, $urandom, $urandom};
      m = (t % 3 == 2) ? 3'($urandom_range(2, 7)) : 3'(t % 3);
      run_op($sformatf("rand%0d_m%0d", t, m), vin, m, 1'b1, model(vin, m));
    end

    // start/validi while busy must neither restart nor reload the buffer
    x_keep = {4'h0, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus_if.in = x_keep; bus_if.validi = 1'b1; bus_if.mode = 3'd0; bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.validi = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.in = ~x_keep; bus_if.validi = 1'b1; bus_if.mode = 3'd1; bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.validi = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) ndone++;
    end
    check_int("busy_start_single_done", ndone, 1);
    check_vec("busy_start_out", bus_if.out, model(x_keep, 3'd0));
    run_op("buffer_kept", 132'h0, 3'd0, 1'b0, model(x_keep, 3'd0));

    // Reset in the middle of RUN
    @(negedge clk);
    bus_if.in = x_keep; bus_if.validi = 1'b1; bus_if.mode = 3'd0; bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.validi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_vec("midrst_out", bus_if.out, '0);
    check_int("midrst_flags", int'({bus_if.done, bus_if.busy, bus_if.trigger}), 0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) ndone++;
    end
    check_int("midrst_no_done", ndone, 0);
    run_op("noload_after_rst", x_keep, 3'd0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
